// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the synchronous FIFO family
package fifo_pkg;

    localparam int FIFO_MIN_DEPTH = 4;

    // Width needed to index n entries, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sfifo_ram_sdp.sv
// sfifo_ram_sdp: simple dual-port storage, one write port and one registered read port
module sfifo_ram_sdp #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write and synchronous read so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/sfifo_ft_param.sv
// sfifo_ft_param: parametrised first-word-fall-through FIFO with watermarks and error pulses
module sfifo_ft_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = clog2_min1(DEPTH);

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < FIFO_MIN_DEPTH) begin : g_bad_depth
        $fatal(1, "sfifo_ft_param: DEPTH must be a power of two and at least FIFO_MIN_DEPTH");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "sfifo_ft_param: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sfifo_ft_param: AE_LEVEL out of range 0..DEPTH-1");
    end
    if (CNT_W != clog2_min1(DEPTH) + 1) begin : g_bad_cnt
        $fatal(1, "sfifo_ft_param: CNT_W is derived from DEPTH and must not be overridden");
    end

    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_acc, rd_acc, byp, ld;
    logic              sel_ram;
    logic [DATA_W-1:0] byp_q, ram_q;

    // Acceptance uses only registered flags; byp marks the edge where the head word is the one being written
    always_comb begin
        wr_acc     = wr_en & ~full;
        rd_acc     = rd_en & ~empty;
        count_nxt  = data_count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        rd_ptr_nxt = rd_ptr + PTR_W'(rd_acc);
        byp        = wr_acc & (empty | (data_count == CNT_W'(1) & rd_acc));
        ld         = rd_acc & (count_nxt != '0) & ~byp;
    end

    sfifo_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (ld),
        .raddr (rd_ptr_nxt),
        .rdata (ram_q)
    );

    // Pointers, count and all status flags advance together from count_nxt so they never disagree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + PTR_W'(wr_acc);
            rd_ptr       <= rd_ptr_nxt;
            data_count   <= count_nxt;
            full         <= count_nxt == CNT_W'(DEPTH);
            empty        <= count_nxt == '0;
            almost_full  <= count_nxt >= CNT_W'(AF_LEVEL);
            almost_empty <= count_nxt <= CNT_W'(AE_LEVEL);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

    // Head-word source: bypass register for words written straight to the head, else the RAM read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ram <= 1'b0;
            byp_q   <= '0;
        end else begin
            sel_ram <= byp ? 1'b0 : (ld ? 1'b1 : sel_ram);
            byp_q   <= byp ? din : byp_q;
        end
    end

    assign dout = sel_ram ? ram_q : byp_q;

endmodule

// File: tb/tb_sfifo_ft_param.sv
// tb_sfifo_ft_param: scoreboard bench for the default FIFO and a tiny 8x4 configuration
module tb_sfifo_ft_param;

    logic         clk, rst;
    logic [127:0] b_din, b_dout;
    logic         b_wr, b_rd, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [8:0]   b_cnt;
    logic [7:0]   s_din, s_dout;
    logic         s_wr, s_rd, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [2:0]   s_cnt;

    int total = 0;
    int bad = 0;

    logic [127:0] q[$];
    int           mc;
    logic         e_ovf, e_udf;
    logic [7:0]   sq[$];
    int           smc;
    logic         se_ovf, se_udf;

    sfifo_ft_param u_big (
        .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .rd_en(b_rd), .dout(b_dout),
        .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .data_count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
    );

    sfifo_ft_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_small (
        .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr), .rd_en(s_rd), .dout(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .data_count(s_cnt), .overflow(s_ovf), .underflow(s_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic w, input logic r, input logic [127:0] d);
        logic wa, ra;
        b_wr = w; b_rd = r; b_din = d;
        wa = w && mc < 256;
        ra = r && mc > 0;
        e_ovf = w && mc == 256;
        e_udf = r && mc == 0;
        @(posedge clk); #1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(d);
        mc = q.size();
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic s_step(input logic w, input logic r, input logic [7:0] d);
        logic wa, ra;
        s_wr = w; s_rd = r; s_din = d;
        wa = w && smc < 4;
        ra = r && smc > 0;
        se_ovf = w && smc == 4;
        se_udf = r && smc == 0;
        @(posedge clk); #1;
        if (ra) void'(sq.pop_front());
        if (wa) sq.push_back(d);
        smc = sq.size();
        s_wr = 1'b0; s_rd = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (b_cnt !== 9'd0) begin bad++; $display("FAIL reset_count act=%0d exp=0", b_cnt); end
        total++; if (b_empty !== 1'b1) begin bad++; $display("FAIL reset_empty act=%b exp=1", b_empty); end
        total++; if (b_full !== 1'b0) begin bad++; $display("FAIL reset_full act=%b exp=0", b_full); end
        total++; if (b_ae !== 1'b1 || b_af !== 1'b0) begin bad++; $display("FAIL reset_almost act=%b%b exp=10", b_ae, b_af); end
        total++; if (b_ovf !== 1'b0 || b_udf !== 1'b0) begin bad++; $display("FAIL reset_err act=%b%b exp=00", b_ovf, b_udf); end
        total++; if (b_dout !== 128'd0) begin bad++; $display("FAIL reset_dout act=%h exp=0", b_dout); end
        total++; if (s_cnt !== 3'd0 || s_empty !== 1'b1 || s_dout !== 8'd0) begin bad++; $display("FAIL reset_small act=%0d/%b/%h exp=0/1/00", s_cnt, s_empty, s_dout); end
        rst = 1'b0;
        q.delete(); mc = 0; sq.delete(); smc = 0;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 128'(i));
            total++; if (b_cnt !== 9'(mc)) begin bad++; $display("FAIL fill_count act=%0d exp=%0d", b_cnt, mc); end
            total++; if (b_af !== (mc >= 252) || b_full !== (mc == 256) || b_empty !== 1'b0) begin bad++; $display("FAIL fill_flags cnt=%0d act_af=%b act_full=%b act_empty=%b", mc, b_af, b_full, b_empty); end
            total++; if (b_dout !== 128'd0) begin bad++; $display("FAIL fill_head act=%h exp=0", b_dout); end
        end
        step(1'b1, 1'b0, 128'd999);
        total++; if (b_ovf !== 1'b1 || e_ovf !== 1'b1) begin bad++; $display("FAIL overflow_pulse act=%b exp=1", b_ovf); end
        total++; if (b_cnt !== 9'd256) begin bad++; $display("FAIL overflow_count act=%0d exp=256", b_cnt); end
        step(1'b0, 1'b0, '0);
        total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL overflow_clear act=%b exp=0", b_ovf); end
    endtask

    task automatic test_drain;
        while (mc > 0) begin
            total++; if (b_dout !== q[0]) begin bad++; $display("FAIL drain_data act=%h exp=%h", b_dout, q[0]); end
            step(1'b0, 1'b1, '0);
            total++; if (b_ae !== (mc <= 4) || b_empty !== (mc == 0) || b_cnt !== 9'(mc)) begin bad++; $display("FAIL drain_flags cnt=%0d act_cnt=%0d act_ae=%b act_empty=%b", mc, b_cnt, b_ae, b_empty); end
        end
        total++; if (b_dout !== 128'd255) begin bad++; $display("FAIL drain_hold act=%h exp=ff", b_dout); end
        step(1'b0, 1'b1, '0);
        total++; if (b_udf !== 1'b1 || e_udf !== 1'b1) begin bad++; $display("FAIL underflow_pulse act=%b exp=1", b_udf); end
        total++; if (b_cnt !== 9'd0) begin bad++; $display("FAIL underflow_count act=%0d exp=0", b_cnt); end
        step(1'b0, 1'b0, '0);
        total++; if (b_udf !== 1'b0) begin bad++; $display("FAIL underflow_clear act=%b exp=0", b_udf); end
    endtask

    task automatic test_single;
        step(1'b1, 1'b0, 128'hA5);
        total++; if (b_empty !== 1'b0) begin bad++; $display("FAIL single_empty act=%b exp=0", b_empty); end
        total++; if (b_dout !== 128'hA5) begin bad++; $display("FAIL single_dout act=%h exp=a5", b_dout); end
        total++; if (b_cnt !== 9'd1) begin bad++; $display("FAIL single_count act=%0d exp=1", b_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] d;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            total++; if (b_dout !== q[0]) begin bad++; $display("FAIL b2b1_data act=%h exp=%h", b_dout, q[0]); end
            step(1'b1, 1'b1, d);
            total++; if (b_cnt !== 9'd1 || b_empty !== 1'b0) begin bad++; $display("FAIL b2b1_count act=%0d exp=1", b_cnt); end
        end
        while (mc < 255) step(1'b1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            total++; if (b_dout !== q[0]) begin bad++; $display("FAIL b2b255_data act=%h exp=%h", b_dout, q[0]); end
            step(1'b1, 1'b1, d);
            total++; if (b_cnt !== 9'd255 || b_full !== 1'b0) begin bad++; $display("FAIL b2b255_count act=%0d exp=255", b_cnt); end
        end
    endtask

    task automatic test_full_rd;
        logic [127:0] nxt;
        step(1'b1, 1'b0, 128'h1234);
        total++; if (b_full !== 1'b1) begin bad++; $display("FAIL fullrd_full act=%b exp=1", b_full); end
        nxt = q[1];
        step(1'b1, 1'b1, 128'hDEAD);
        total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL fullrd_ovf act=%b exp=1", b_ovf); end
        total++; if (b_cnt !== 9'd255 || mc != 255) begin bad++; $display("FAIL fullrd_count act=%0d exp=255", b_cnt); end
        total++; if (b_dout !== nxt) begin bad++; $display("FAIL fullrd_data act=%h exp=%h", b_dout, nxt); end
    endtask

    task automatic test_reset_mid;
        while (mc > 100) begin
            total++; if (b_dout !== q[0]) begin bad++; $display("FAIL mid_data act=%h exp=%h", b_dout, q[0]); end
            step(1'b0, 1'b1, '0);
        end
        b_wr = 1'b1; b_din = 128'h77;
        rst = 1'b1;
        #1;
        total++; if (b_cnt !== 9'd0 || b_empty !== 1'b1 || b_full !== 1'b0 || b_dout !== 128'd0) begin bad++; $display("FAIL mid_reset act=%0d/%b/%b/%h exp=0/1/0/0", b_cnt, b_empty, b_full, b_dout); end
        total++; if (b_ae !== 1'b1 || b_af !== 1'b0) begin bad++; $display("FAIL mid_reset_almost act=%b%b exp=10", b_ae, b_af); end
        @(posedge clk); #1;
        total++; if (b_cnt !== 9'd0) begin bad++; $display("FAIL mid_reset_hold act=%0d exp=0", b_cnt); end
        b_wr = 1'b0;
        rst = 1'b0;
        q.delete(); mc = 0;
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 128'(i));
        while (mc > 0) begin
            total++; if (b_dout !== q[0]) begin bad++; $display("FAIL post_reset_data act=%h exp=%h", b_dout, q[0]); end
            step(1'b0, 1'b1, '0);
        end
        total++; if (b_empty !== 1'b1) begin bad++; $display("FAIL post_reset_empty act=%b exp=1", b_empty); end
    endtask

    task automatic test_small;
        for (int i = 0; i < 5; i++) begin
            s_step(1'b1, 1'b0, 8'(8'h10 + i));
            total++; if (s_cnt !== 3'(smc) || s_full !== (smc == 4) || s_af !== (smc >= 3) || s_ae !== (smc <= 1)) begin bad++; $display("FAIL small_fill cnt=%0d act=%0d full=%b af=%b ae=%b", smc, s_cnt, s_full, s_af, s_ae); end
            total++; if (s_ovf !== se_ovf) begin bad++; $display("FAIL small_ovf act=%b exp=%b", s_ovf, se_ovf); end
        end
        for (int i = 0; i < 20; i++) begin
            if (smc > 0) begin
                total++; if (s_dout !== sq[0]) begin bad++; $display("FAIL small_b2b_data act=%h exp=%h", s_dout, sq[0]); end
            end
            s_step(1'b1, 1'b1, 8'($urandom));
            total++; if (s_cnt !== 3'(smc)) begin bad++; $display("FAIL small_b2b_count act=%0d exp=%0d", s_cnt, smc); end
        end
        for (int i = 0; i < 5; i++) begin
            if (smc > 0) begin
                total++; if (s_dout !== sq[0]) begin bad++; $display("FAIL small_drain_data act=%h exp=%h", s_dout, sq[0]); end
            end
            s_step(1'b0, 1'b1, '0);
            total++; if (s_udf !== se_udf || s_empty !== (smc == 0) || s_ae !== (smc <= 1)) begin bad++; $display("FAIL small_drain cnt=%0d udf=%b empty=%b ae=%b", smc, s_udf, s_empty, s_ae); end
        end
    endtask

    initial begin
        rst = 1'b1;
        b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
        s_wr = 1'b0; s_rd = 1'b0; s_din = '0;
        mc = 0; smc = 0;
        test_reset;
        test_fill;
        test_drain;
        test_single;
        test_back_to_back;
        test_full_rd;
        test_reset_mid;
        test_small;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sfifo_ft_param.md
# sfifo_ft_param

Parametrised synchronous first-word-fall-through FIFO. It is the successor to the fixed 128×256 FT FIFO used throughout the packet buffer and queue manager datapaths. Width, depth and almost-full/almost-empty thresholds are generic. It adds programmable watermarks and overflow/underflow error pulses, so the same block serves descriptor queues, cell buffers and metadata side-FIFOs without a per-size netlist.

## Interface
Parameters:
- DATA_W, 128, data width in bits (≥1)
- DEPTH, 256, capacity in words; power of two, ≥4
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- CNT_W, $clog2(DEPTH)+1, width of data_count (derived, not overridden)

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous assert, active-high; clears all state
- din  in  DATA_W  write data
- wr_en  in  1  write request
- rd_en  in  1  read request / pop of head word
- dout  out  DATA_W  head word; valid whenever empty=0
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- data_count  out  CNT_W  words held, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected last cycle
- underflow  out  1  one-cycle pulse: read rejected last cycle

## Operation
- Write accepted at a rising edge iff wr_en=1 and full=0. A write while full is dropped and overflow=1 for the following cycle. A simultaneous rd_en does not admit the write; full gates it unconditionally.
- Read accepted iff rd_en=1 and empty=0. It pops the head word, and dout shows the next word in the cycle after the edge. A read while empty is dropped and underflow=1 for the following cycle.
- FWFT: dout is the oldest unread word with no read request needed. When empty=1, dout holds the last value it had; it is not required to be zero after the first write.
- Count update per edge: +1 for accepted write only, −1 for accepted read only, unchanged for both or neither. data_count, full, empty, almost_full and almost_empty are all registered and derived from the same count. They are mutually consistent in every cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. There is no special case at the wrap.
- Simultaneous accepted read and write at count=1: dout advances to the newly written word, count stays 1 and empty stays 0.
- Data order is strict FIFO. Every accepted word is delivered exactly once.

## Timing
- Reset values: data_count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0) (0 for all legal values), overflow=0, underflow=0, dout=0, pointers=0.
- Reset asserted mid-operation: all contents are discarded immediately, outputs return to reset values asynchronously, and no write or read is accepted while rst=1.
- Write-to-dout latency on an empty FIFO: write at edge T gives empty=0 and dout=din(T) from edge T (visible in cycle T+1).
- Read-to-next-word latency: 0 extra cycles; the next head word is on dout in the cycle after the popping edge.
- All outputs are driven from flops or from the storage read port with a registered address. There is no combinational path from wr_en/rd_en to any output.

## Structure
- Shared package fifo_pkg: function clog2_min1 for pointer/count widths, and a constant FIFO_MIN_DEPTH=4. Elaboration-time assertions check that DEPTH is a power of two and that AF_LEVEL/AE_LEVEL are in range.
- Sub-module sfifo_ram_sdp: simple dual-port storage (DATA_W × DEPTH, one write port, one read port with registered read address) that infers block RAM. Control, count, flags and error pulses stay in the top level.

## Test plan
- Reset then 256 back-to-back writes of 0..255 (DATA_W=128, DEPTH=256) -> full=1 after the 256th edge, data_count=256, almost_full from count 252. The 257th write gives an overflow pulse, and count stays 256.
- Drain the full FIFO with continuous rd_en -> dout sequence 0..255 in order, almost_empty from count 4, and empty=1 after the last pop. One extra read gives an underflow pulse.
- Single write of 0xA5 into an empty FIFO -> empty=0 and dout=0xA5 in the next cycle, data_count=1.
- Simultaneous wr/rd at count=1 and at count=DEPTH−1 for 1000 cycles -> count constant, data in order. Repeated across pointer wrap, with no loss or duplication.
- Write while full with rd_en=1 -> read accepted, write dropped, overflow=1, count=DEPTH−1.
- Assert rst at count=100 mid-stream -> outputs at reset values in the same cycle. Post-reset writes of 1,2,3 read back as 1,2,3. Also run with DATA_W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
